// File: rtl/id_operand_stage_pkg.sv
// Shared decode constants and operand-select helper for the ID operand stage.
package id_operand_stage_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RDATA_WIDTH = 32;

  localparam logic [31:0] ZERO = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  localparam logic [6:0] INST_TYPE_I = 7'b0010011;
  localparam logic [6:0] INST_TYPE_R = 7'b0110011;
  localparam logic [6:0] INST_LUI    = 7'b0110111;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRX = 3'b101;

  typedef enum logic [2:0] {
    OPS_NONE,
    OPS_SHAMT,
    OPS_IMM,
    OPS_REG,
    OPS_UPPER
  } op_sel_e;

  function automatic op_sel_e op_sel(input logic [6:0] opcode, input logic [2:0] funct3);
    op_sel_e sel;
    sel = OPS_NONE;
    if (opcode == INST_TYPE_I) begin
      sel = (funct3 == FUNCT3_SLL || funct3 == FUNCT3_SRX) ? OPS_SHAMT : OPS_IMM;
    end else if (opcode == INST_TYPE_R) begin
      sel = OPS_REG;
    end else if (opcode == INST_LUI) begin
      sel = OPS_UPPER;
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_operand_stage_mux.sv
// Combinational operand former: immediates, x0 masking, optional writeback bypass.
// Bypass from the writeback port is compiled in with `define ID_FORWARD_EN.
module id_operand_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic [INST_WIDTH-1:0] inst,
  input  logic [4:0]            reg1_raddr,
  input  logic [4:0]            reg2_raddr,
  input  logic [DATA_WIDTH-1:0] reg1_rdata,
  input  logic [DATA_WIDTH-1:0] reg2_rdata,
  input  logic                  wb_we,
  input  logic [4:0]            wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2
);

  logic signed [DATA_WIDTH-1:0] imm_i;
  logic        [DATA_WIDTH-1:0] imm_shamt;
  logic        [DATA_WIDTH-1:0] imm_u;
  logic        [DATA_WIDTH-1:0] rs1_val;
  logic        [DATA_WIDTH-1:0] rs2_val;
  logic                         unused_inst;
  op_sel_e                      sel;

  assign sel         = op_sel(inst[6:0], inst[14:12]);
  assign imm_i       = DATA_WIDTH'($signed(inst[31:20]));
  assign imm_shamt   = DATA_WIDTH'(inst[24:20]);
  assign imm_u       = DATA_WIDTH'({inst[31:12], 12'b0});
  assign unused_inst = ^inst[11:7];

`ifdef ID_FORWARD_EN
  // Bypass only on a live, non-x0 write that targets an address actually being read.
  assign rs1_val = (reg1_raddr == 5'd0) ? '0 :
                   (wb_we && wb_waddr == reg1_raddr) ? wb_wdata : reg1_rdata;
  assign rs2_val = (reg2_raddr == 5'd0) ? '0 :
                   (wb_we && wb_waddr == reg2_raddr) ? wb_wdata : reg2_rdata;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};
  assign rs1_val   = (reg1_raddr == 5'd0) ? '0 : reg1_rdata;
  assign rs2_val   = (reg2_raddr == 5'd0) ? '0 : reg2_rdata;
`endif

  always_comb begin
    op1 = '0;
    op2 = '0;
    case (sel)
      OPS_SHAMT: begin op1 = rs1_val; op2 = imm_shamt; end
      OPS_IMM:   begin op1 = rs1_val; op2 = imm_i;     end
      OPS_REG:   begin op1 = rs1_val; op2 = rs2_val;   end
      OPS_UPPER: begin op1 = imm_u;   op2 = '0;        end
      default:   begin op1 = '0;      op2 = '0;        end
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: register-file read addressing and the ID/EX register.
// Optional writeback bypass is enabled by `define ID_FORWARD_EN.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic                  inst_valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic [4:0]            reg1_raddr_o,
  output logic [4:0]            reg2_raddr_o,
  input  logic [DATA_WIDTH-1:0] reg1_rdata_i,
  input  logic [DATA_WIDTH-1:0] reg2_rdata_i,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  output logic [DATA_WIDTH-1:0] op1_o,
  output logic [DATA_WIDTH-1:0] op2_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [4:0]            rd_o,
  output logic                  valid_o
);

  logic [6:0]            opcode_p0;
  logic [DATA_WIDTH-1:0] op1_p0;
  logic [DATA_WIDTH-1:0] op2_p0;

  logic [DATA_WIDTH-1:0] op1_p1;
  logic [DATA_WIDTH-1:0] op2_p1;
  logic [INST_WIDTH-1:0] inst_p1;
  logic [4:0]            rd_p1;
  logic                  vld_p1;

  assign opcode_p0 = inst_i[6:0];

  always_comb begin
    reg1_raddr_o = 5'd0;
    reg2_raddr_o = 5'd0;
    if (opcode_p0 == INST_TYPE_I || opcode_p0 == INST_TYPE_R) begin
      reg1_raddr_o = inst_i[19:15];
    end
    if (opcode_p0 == INST_TYPE_R) begin
      reg2_raddr_o = inst_i[24:20];
    end
  end

  id_operand_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_mux (
    .inst       (inst_i),
    .reg1_raddr (reg1_raddr_o),
    .reg2_raddr (reg2_raddr_o),
    .reg1_rdata (reg1_rdata_i),
    .reg2_rdata (reg2_rdata_i),
    .wb_we      (wb_we_i),
    .wb_waddr   (wb_waddr_i),
    .wb_wdata   (wb_wdata_i),
    .op1        (op1_p0),
    .op2        (op2_p0)
  );

  // ID/EX boundary: an invalid input slot is loaded as a bubble, same as a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!stall_i && !inst_valid_i)) begin
      op1_p1  <= '0;
      op2_p1  <= '0;
      inst_p1 <= NOP_INST;
      rd_p1   <= 5'd0;
      vld_p1  <= 1'b0;
    end else if (!stall_i) begin
      op1_p1  <= op1_p0;
      op2_p1  <= op2_p0;
      inst_p1 <= inst_i;
      rd_p1   <= inst_i[11:7];
      vld_p1  <= 1'b1;
    end
  end

  assign op1_o   = op1_p1;
  assign op2_o   = op2_p1;
  assign inst_o  = inst_p1;
  assign rd_o    = rd_p1;
  assign valid_o = vld_p1;

endmodule
